// File: rtl/uart_transmitter_if.sv
// Purpose : handshake/serial bundle between a UART TX client and uart_transmitter.
// Ports   : tick (baud strobe), tx_start/tx_data (request), tx_ready/tx_busy/tx_done (status), tx_line (serial out).
// Modports: master = client side (drives request and tick), slave = transmitter side.
interface uart_transmitter_if #(
  parameter int DATA_BITS = 8
);
  logic                 tick;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx_line;

  modport master (
    output tick, tx_start, tx_data,
    input  tx_ready, tx_busy, tx_done, tx_line
  );

  modport slave (
    input  tick, tx_start, tx_data,
    output tx_ready, tx_busy, tx_done, tx_line
  );
endinterface

// File: rtl/uart_transmitter.sv
// Purpose : UART transmitter, serialises one DATA_BITS word into start/data/[parity]/stop, LSB first.
// Latency : accepts tx_start 1 clk after request, tx_line registered (changes 1 clk after qualifying tick).
// Backpressure: tx_start sampled only while tx_ready=1; requests while busy are dropped, no queueing.
// Ports   : clk_i, rst_i (sync, active-high), tx_if (slave modport of uart_transmitter_if).
module uart_transmitter #(
  parameter int DATA_BITS      = 8,
  parameter int TICKS_PER_BIT  = 16,
  parameter int STOP_BIT_TICKS = 16,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  uart_transmitter_if.slave  tx_if
);

  localparam int MAX_TICKS = (TICKS_PER_BIT > STOP_BIT_TICKS) ? TICKS_PER_BIT : STOP_BIT_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] BIT_LAST  = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_BIT_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state logic: every counter moves only on a tick, so tick-less cycles hold everything.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_if.tx_start) begin
          shift_d    = tx_if.tx_data;
          parity_d   = (^tx_if.tx_data) ^ 1'(PARITY_ODD);
          tick_cnt_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tx_if.tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tx_if.tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            shift_d    = shift_q >> 1;
            tick_cnt_d = '0;
            if (bit_cnt_q == DATA_LAST) begin
              state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tx_if.tick) begin
          if (tick_cnt_q == BIT_LAST) begin
            tick_cnt_d = '0;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (tx_if.tick) begin
          if (tick_cnt_q == STOP_LAST) begin
            // A reset landing on the final stop tick aborts the frame, so no completion pulse.
            done       = ~rst_i;
            tick_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  // Line level is decoded from the next state and registered, so the pin never glitches and
  // moves exactly one clock after the tick that caused the transition.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_if.tx_ready = (state_q == S_IDLE);
  assign tx_if.tx_busy  = (state_q != S_IDLE);
  assign tx_if.tx_done  = done;
  assign tx_if.tx_line  = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Purpose : bench for uart_transmitter, four parameterisations checked every cycle against a frame model.
// Latency : model predicts the line from ticks counted since accept (bit index = ticks / TICKS_PER_BIT).
// Backpressure: requests are dropped by the model while a frame is in flight, same as the contract.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int NI = 4;
  localparam int P_DB  [NI] = '{8, 8, 8, 5};
  localparam int P_TPB [NI] = '{16, 16, 16, 8};
  localparam int P_STB [NI] = '{16, 16, 16, 32};
  localparam int P_PE  [NI] = '{0, 1, 1, 0};
  localparam int P_PO  [NI] = '{0, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst_s = 1'b1;
  logic       tick_s = 1'b0;
  logic       start_s [NI];
  logic [7:0] data_s  [NI];
  logic       tx_w   [NI];
  logic       rdy_w  [NI];
  logic       bsy_w  [NI];
  logic       done_w [NI];

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  chk_en   = 1'b0;
  int  tick_mode = 3;  // 0 every clk, 1 random, 2 every 27 clks, 3 never
  int  tick_div  = 0;
  int  done0_cnt = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    #1;
    case (tick_mode)
      0: tick_s = 1'b1;
      1: tick_s = 1'($urandom_range(0, 1));
      2: begin
        tick_s   = (tick_div == 26);
        tick_div = (tick_div == 26) ? 0 : tick_div + 1;
      end
      default: tick_s = 1'b0;
    endcase
  end

  always @(negedge clk) if (done_w[0] === 1'b1) done0_cnt++;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int DB  = P_DB[g];
    localparam int TPB = P_TPB[g];
    localparam int STB = P_STB[g];
    localparam int PE  = P_PE[g];
    localparam int PO  = P_PO[g];
    localparam int LEN = TPB * (1 + DB + PE) + STB;

    uart_transmitter_if #(.DATA_BITS(DB)) bus ();
    assign bus.tick     = tick_s;
    assign bus.tx_start = start_s[g];
    assign bus.tx_data  = data_s[g][DB-1:0];
    assign tx_w[g]      = bus.tx_line;
    assign rdy_w[g]     = bus.tx_ready;
    assign bsy_w[g]     = bus.tx_busy;
    assign done_w[g]    = bus.tx_done;

    uart_transmitter #(
      .DATA_BITS(DB), .TICKS_PER_BIT(TPB), .STOP_BIT_TICKS(STB),
      .PARITY_EN(PE), .PARITY_ODD(PO)
    ) dut (
      .clk_i(clk),
      .rst_i(rst_s),
      .tx_if(bus)
    );

    // Frame model: busy_m/n_m = frame in flight and ticks counted since accept.
    bit         busy_m = 1'b0;
    int         n_m    = 0;
    logic [7:0] dat_m  = 8'h00;

    function automatic logic exp_bit(input int n);
      int k;
      k = n / TPB;
      if (k == 0) return 1'b0;
      if (k <= DB) return dat_m[k-1];
      if (PE != 0 && k == DB + 1) return 1'(($countones(dat_m) + PO) % 2);
      return 1'b1;
    endfunction

    always @(posedge clk) begin
      if (rst_s) begin
        busy_m = 1'b0;
      end else if (!busy_m) begin
        if (start_s[g]) begin
          busy_m = 1'b1;
          n_m    = 0;
          dat_m  = data_s[g] & 8'((1 << DB) - 1);
        end
      end else if (tick_s) begin
        n_m++;
        if (n_m == LEN) busy_m = 1'b0;
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("g%0d tx", g), 32'(tx_w[g]), 32'(busy_m ? exp_bit(n_m) : 1'b1));
        chk($sformatf("g%0d ready", g), 32'(rdy_w[g]), 32'(!busy_m));
        chk($sformatf("g%0d busy", g), 32'(bsy_w[g]), 32'(busy_m));
        chk($sformatf("g%0d done", g), 32'(done_w[g]),
            32'(busy_m && tick_s && !rst_s && n_m == LEN - 1));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples the line mid-bit (16 clk bits, tick every clk), starting at the current negedge as c=0.
  task automatic sample_frame(input int g, input int nb, output logic [15:0] bits, output int done_at);
    done_at = -1;
    bits    = '0;
    for (int c = 0; c < 1000; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 16 == 8 && c / 16 < nb) bits[c/16] = tx_w[g];
      if (done_w[g]) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int g, input string tag);
    int guard;
    guard = 0;
    while (rdy_w[g] !== 1'b1 && guard < 20000) begin
      step();
      guard++;
    end
    if (guard >= 20000) chk(tag, 32'(rdy_w[g]), 32'd1);
  endtask

  // Mid-bit receiver: after the start edge, sample at ticks 8+16j.
  task automatic rx_byte(output logic [7:0] got, output logic start_bit);
    int tc, j, guard;
    tc = 0; j = 0; guard = 0; got = '0; start_bit = 1'b1;
    while (j < 9 && guard < 20000) begin
      @(posedge clk);
      guard++;
      if (tick_s) begin
        tc++;
        if (tc == 8 + 16 * j) begin
          @(negedge clk);
          if (j == 0) start_bit = tx_w[0];
          else got[j-1] = tx_w[0];
          j++;
        end
      end
    end
    if (guard >= 20000) chk("rx timeout", 32'(j), 32'd9);
  endtask

  initial begin
    logic [15:0] b0, b1;
    int          d0, d1;
    logic [7:0]  rx_dat;
    logic        rx_sb;
    logic [7:0]  lb [4];
    int          dc;

    lb = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    for (int g = 0; g < NI; g++) begin
      start_s[g] = 1'b0;
      data_s[g]  = 8'h00;
    end

    // Reset held 3 cycles, then long idle with random ticks.
    repeat (3) step();
    chk_en = 1'b1;
    rst_s  = 1'b0;
    tick_mode = 1;
    repeat (1000) step();
    chk("idle tx", 32'(tx_w[0]), 32'd1);
    chk("idle ready", 32'(rdy_w[0]), 32'd1);

    // 0x55, 8N1, tick every clock.
    tick_mode = 0;
    step();
    start_s[0] = 1'b1; data_s[0] = 8'h55;
    step();
    start_s[0] = 1'b0;
    @(negedge clk);
    sample_frame(0, 10, b0, d0);
    chk("55 bits", 32'(b0[9:0]), 32'({1'b1, 8'h55, 1'b0}));
    chk("55 done cycle", 32'(d0), 32'd159);
    @(negedge clk);
    chk("55 ready after", 32'(rdy_w[0]), 32'd1);

    // Parity even/odd, 0x07.
    step();
    start_s[1] = 1'b1; data_s[1] = 8'h07;
    start_s[2] = 1'b1; data_s[2] = 8'h07;
    step();
    start_s[1] = 1'b0; start_s[2] = 1'b0;
    @(negedge clk);
    fork
      sample_frame(1, 11, b0, d0);
      sample_frame(2, 11, b1, d1);
    join
    chk("even bits", 32'(b0[10:0]), 32'({1'b1, 1'b1, 8'h07, 1'b0}));
    chk("odd bits", 32'(b1[10:0]), 32'({1'b1, 1'b0, 8'h07, 1'b0}));
    chk("even len", 32'(d0), 32'd175);
    chk("odd len", 32'(d1), 32'd175);

    // Start while busy is dropped; start held from the done cycle is accepted a cycle later.
    step();
    start_s[0] = 1'b1; data_s[0] = 8'h12;
    step();
    start_s[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      start_s[0] = (i >= 20 && i < 23);
      data_s[0]  = 8'hA3;
      step();
    end
    start_s[0] = 1'b0;
    @(negedge clk);
    sample_frame(0, 0, b0, d0);
    chk("busy start ignored", 32'(d0), 32'd119);
    start_s[0] = 1'b1;
    @(negedge clk);
    chk("done+1 ready", 32'(rdy_w[0]), 32'd1);
    chk("done+1 tx", 32'(tx_w[0]), 32'd1);
    @(negedge clk);
    chk("done+2 ready", 32'(rdy_w[0]), 32'd0);
    chk("done+2 tx", 32'(tx_w[0]), 32'd0);
    start_s[0] = 1'b0;
    sample_frame(0, 10, b0, d0);
    chk("A3 bits", 32'(b0[9:0]), 32'({1'b1, 8'hA3, 1'b0}));
    chk("A3 done cycle", 32'(d0), 32'd159);

    // Reset during data bit 4 aborts the frame.
    step();
    dc = done0_cnt;
    start_s[0] = 1'b1; data_s[0] = 8'h96;
    step();
    start_s[0] = 1'b0;
    repeat (84) step();
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    @(negedge clk);
    chk("abort tx", 32'(tx_w[0]), 32'd1);
    chk("abort ready", 32'(rdy_w[0]), 32'd1);
    chk("abort no done", 32'(done0_cnt - dc), 32'd0);
    step();
    start_s[0] = 1'b1; data_s[0] = 8'h3C;
    step();
    start_s[0] = 1'b0;
    @(negedge clk);
    sample_frame(0, 10, b0, d0);
    chk("3C bits", 32'(b0[9:0]), 32'({1'b1, 8'h3C, 1'b0}));
    chk("3C done cycle", 32'(d0), 32'd159);

    // Slow baud (tick every 27 clocks), decoded by a mid-bit receiver.
    step();
    tick_mode = 2;
    dc = done0_cnt;
    for (int i = 0; i < 4; i++) begin
      wait_idle(0, "lb idle");
      start_s[0] = 1'b1; data_s[0] = lb[i];
      step();
      start_s[0] = 1'b0;
      rx_byte(rx_dat, rx_sb);
      chk($sformatf("lb start %0d", i), 32'(rx_sb), 32'd0);
      chk($sformatf("lb data %0d", i), 32'(rx_dat), 32'(lb[i]));
    end
    wait_idle(0, "lb end idle");
    chk("lb done count", 32'(done0_cnt - dc), 32'd4);

    // Random traffic on all parameterisations with random ticks.
    tick_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      for (int g = 0; g < NI; g++) begin
        start_s[g] = ($urandom_range(0, 7) == 0);
        data_s[g]  = 8'($urandom);
      end
      step();
    end
    for (int g = 0; g < NI; g++) start_s[g] = 1'b0;
    tick_mode = 0;
    for (int g = 0; g < NI; g++) wait_idle(g, "final idle");
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
